// File: rtl/tristate_bus_receiver_if.sv
// rtl/tristate_bus_receiver_if.sv - bus-side and consumer-side signal bundle for tristate_bus_receiver
interface tristate_bus_receiver_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] bus_in;
    logic [NSRC-1:0]  drive_en;
    logic             capture;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0]    out_src;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             full;
    logic             err_contention;
    logic             err_float;
    logic             err_overflow;
    logic             err_clr;

    modport master (
        output bus_in, drive_en, capture, out_ready, err_clr,
        input  out_data, out_src, out_valid, level, full,
               err_contention, err_float, err_overflow
    );

    modport slave (
        input  bus_in, drive_en, capture, out_ready, err_clr,
        output out_data, out_src, out_valid, level, full,
               err_contention, err_float, err_overflow
    );
endinterface

// File: rtl/tristate_bus_receiver.sv
// rtl/tristate_bus_receiver.sv - samples the shared tri-state bus and queues source-tagged words in a FWFT FIFO
module tristate_bus_receiver #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tristate_bus_receiver_if.slave  bus
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(NSRC + 1);
    localparam int EW = WIDTH + SW;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] last_q, last_d;
    logic          err_c_q, err_c_d;
    logic          err_f_q, err_f_d;
    logic          err_o_q, err_o_d;

    logic [CW-1:0] en_cnt;
    logic [SW-1:0] en_idx;
    logic          empty, is_full, qualified, pop, push;

    always_comb begin
        en_cnt = '0;
        en_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.drive_en[i]) begin
                en_cnt = en_cnt + CW'(1);
                en_idx = SW'(i);
            end
        end
    end

    assign empty     = (level_q == '0);
    assign is_full   = (level_q == LW'(DEPTH));
    assign qualified = bus.capture && (en_cnt == CW'(1));
    assign pop       = !empty && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = qualified && (!is_full || pop);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
        err_c_d  = (bus.capture && (en_cnt > CW'(1))) || (err_c_q && !bus.err_clr);
        err_f_d  = (bus.capture && (en_cnt == '0))    || (err_f_q && !bus.err_clr);
        err_o_d  = (qualified && !push)               || (err_o_q && !bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
            err_c_q  <= 1'b0;
            err_f_q  <= 1'b0;
            err_o_q  <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= {bus.bus_in, en_idx};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
            err_c_q  <= err_c_d;
            err_f_q  <= err_f_d;
            err_o_q  <= err_o_d;
        end
    end

    // When empty the head slot may hold stale data, so show the last popped word instead.
    assign bus.out_data       = empty ? last_q[EW-1:SW] : mem_q[rd_ptr_q][EW-1:SW];
    assign bus.out_src        = empty ? last_q[SW-1:0]  : mem_q[rd_ptr_q][SW-1:0];
    assign bus.out_valid      = !empty;
    assign bus.level          = level_q;
    assign bus.full           = is_full;
    assign bus.err_contention = err_c_q;
    assign bus.err_float      = err_f_q;
    assign bus.err_overflow   = err_o_q;
endmodule

// File: doc/tristate_bus_receiver.md
Name: tristate_bus_receiver

Overview:
- Receiving end of the shared tri-state data bus driven by tristate_bus_bus drivers, one per source.
- Samples the resolved bus on a capture strobe and checks that exactly one driver enable is active.
- Tags each accepted word with the driving source index and buffers it in a first-word-fall-through FIFO with a valid/ready output.
- Flags protocol errors (bus contention, floating-bus capture, overflow) as sticky status bits.

Parameters:
- WIDTH, 8, bus data width in bits.
- NSRC, 4, number of tri-state drivers on the bus (2..16).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- bus_in  input  WIDTH  resolved shared tri-state bus net.
- drive_en  input  NSRC  copy of each driver's enable; bit i = source i driving.
- capture  input  1  request to sample bus_in this cycle.
- out_data  output  WIDTH  head-of-FIFO data word.
- out_src  output  $clog2(NSRC)  source index tagged to out_data.
- out_valid  output  1  FIFO non-empty; out_data/out_src valid.
- out_ready  input  1  consumer accepts the head word when out_valid=1.
- level  output  $clog2(DEPTH)+1  number of stored entries.
- full  output  1  level == DEPTH.
- err_contention  output  1  sticky: capture with two or more drive_en bits set.
- err_float  output  1  sticky: capture with drive_en == 0.
- err_overflow  output  1  sticky: valid capture dropped because FIFO full.
- err_clr  input  1  clears all three sticky error bits.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears all state. Outputs: out_valid=0, level=0, full=0, all err_*=0, out_data=0, out_src=0. Reset mid-transfer discards all buffered words.
- Qualified capture: capture=1 and popcount(drive_en)==1. out_src tag = index of the set bit.
- Push: a qualified capture with (!full or pop this cycle) writes {bus_in, index} at the clk edge. No combinational path from bus_in to outputs.
- Pop: out_valid && out_ready at a clk edge. out_ready is ignored while out_valid=0.
- Latency: a word pushed into an empty FIFO gives out_valid=1 and out_data=bus_in in the cycle after the capture edge (one cycle).
- FWFT: out_data/out_src always reflect the head entry. They hold while out_valid=1 && !out_ready. With no valid entry they hold the last popped value (0 after reset).
- Simultaneous push and pop:
  - Not empty: level unchanged, both take effect.
  - Full: push accepted, no overflow.
  - Empty: pop does not occur, push proceeds.
- Overflow: a qualified capture while full and not popping is dropped, sets err_overflow, and leaves the FIFO untouched.
- Contention: capture=1 with popcount(drive_en)>=2 sets err_contention; no push.
- Float: capture=1 with drive_en==0 sets err_float; no push.
- capture=0: drive_en is ignored; no checks, no push.
- err_clr: clears err_* at the edge. If an error condition occurs in the same cycle, the set wins (bit reads 1 next cycle).
- Pointers: read/write pointers are log2(DEPTH) bits and wrap naturally; full/empty derive from level.
- Storage is registers; no memory macro.

Test Plan:
- Reset, then drive_en=4'b0010, bus_in=8'hA5, capture=1 for one cycle -> next cycle out_valid=1, out_data=8'hA5, out_src=1, level=1.
- With out_ready=0, capture 8'h01..8'h05 from source 3 on five consecutive cycles -> level=4, full=1, err_overflow=1; draining yields 01,02,03,04 in order with out_src=3.
- Full FIFO, capture 8'h77 from source 0 with out_ready=1 in the same cycle -> no overflow, level stays 4, 8'h77 emerges last.
- capture=1, drive_en=4'b0110 -> err_contention=1, level unchanged. Then capture=1, drive_en=0 -> err_float=1. Then err_clr=1 alone -> both clear next cycle.
- err_clr=1 in the same cycle as a contention capture -> err_contention=1 next cycle.
- Push three words, assert rst_n=0 for one cycle mid-drain -> out_valid=0, level=0, all errors 0. The next capture of 8'h3C is the first word out.
